// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first,
// with a start/busy/done handshake and a registered sum/carry-out.

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ ci;
  assign cout = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);
  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, s_sr_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             load;
  logic             fa_sum, fa_cout;

  fa u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .ci   (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN:  if (cnt_q == LAST) state_d = DONE;
      DONE: begin
        load    = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift then overwrite the MSB so the expression stays legal for WIDTH=1.
  always_comb begin
    s_sr_d           = s_sr_q >> 1;
    s_sr_d[WIDTH-1]  = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_sr_q  <= a_in;
        b_sr_q  <= b_in;
        s_sr_q  <= '0;
        carry_q <= ci_in;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_sr_q  <= a_sr_q >> 1;
        b_sr_q  <= b_sr_q >> 1;
        s_sr_q  <= s_sr_d;
        carry_q <= fa_cout;
        cnt_q   <= cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_q  <= s_sr_d;
          cout_q <= fa_cout;
        end
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum_out  = sum_q;
  assign cout_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and swept checks of serial_adder at WIDTH=8 and WIDTH=1.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       ci_in = 1'b0;
  logic       busy, done, cout_out;
  logic [7:0] sum_out;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ci1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .ci_in(ci_in), .busy(busy), .done(done), .sum_out(sum_out),
    .cout_out(cout_out)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
    .ci_in(ci1), .busy(busy1), .done(done1), .sum_out(sum1),
    .cout_out(cout1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch at a negedge, accepted at the following posedge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a_in = a; b_in = b; ci_in = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observe WIDTH RUN cycles then the DONE cycle.
  task automatic finish_add(input string tag, input logic [8:0] exp, input bit timing);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (timing) begin
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check_eq({tag, "_nodone"}, {31'b0, done}, 32'd0);
      end
    end
    @(negedge clk);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
    if (timing) check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_res"}, {23'b0, cout_out, sum_out}, {23'b0, exp});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int unsigned dcount;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_state", {22'b0, busy, done, cout_out, sum_out}, 32'd0);
    check_eq("rst_x", {31'b0, $isunknown({busy, done, cout_out, sum_out, busy1, done1, cout1, sum1})}, 32'd0);

    launch(8'h5A, 8'h3C, 1'b0); finish_add("add_5a_3c", 9'h096, 1);
    check_eq("x_after", {31'b0, $isunknown({busy, done, cout_out, sum_out})}, 32'd0);
    launch(8'hFF, 8'h01, 1'b0); finish_add("add_ff_01", 9'h100, 1);
    launch(8'hFF, 8'hFF, 1'b1); finish_add("add_ff_ff_1", 9'h1FF, 1);

    // start raised during RUN must be ignored
    launch(8'h10, 8'h20, 1'b0);
    dcount = 0;
    repeat (2) @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("hold_during_run", {23'b0, cout_out, sum_out}, 32'h1FF);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        check_eq("ign_res", {23'b0, cout_out, sum_out}, 32'h030);
      end
    end
    check_eq("ign_one_done", dcount, 32'd1);

    // start held high: back-to-back adds, one gap cycle each
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h01; ci_in = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      finish_add("b2b", 9'h002, 1);
      if (k == 2) start = 1'b0;
    end
    @(negedge clk);
    check_eq("b2b_stop", {30'b0, busy, done}, 32'd0);

    // reset mid-operation
    launch(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst", {22'b0, busy, done, cout_out, sum_out}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check_eq("midrst_nodone", dcount, 32'd0);
    launch(8'hF0, 8'h0F, 1'b0); finish_add("after_rst", 9'h0FF, 1);

    // sweep
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      launch(ra, rb, rc);
      finish_add("sweep", 9'(ra) + 9'(rb) + 9'(rc), 0);
    end

    // WIDTH=1 full-adder truth table
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      a1 = 1'(v >> 2); b1 = 1'(v >> 1); ci1 = 1'(v); start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      check_eq("w1_busy", {30'b0, busy1, done1}, 32'd2);
      @(negedge clk);
      check_eq("w1_done", {31'b0, done1}, 32'd1);
      check_eq("w1_res", {30'b0, cout1, sum1},
               32'((v >> 2) & 1) + 32'((v >> 1) & 1) + 32'(v & 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
